nbit_seq_decoder: RTL and testbench

- Receive-side decoder and checker for the team's n-bit counter codes: Gray, Johnson (twisted-ring) and one-hot ring.
- Takes a qualified code word per cycle and maps it back to its binary sequence index.
- Validates each word as a legal code word and as the legal successor of the previous word.
- Tracks lock and counts errors; sits at the far end of a link carrying counter state from a counter block.

---
 rtl/nbit_seq_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_nbit_seq_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nbit_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : nbit_seq_decoder
// Brief    : Receive-side decoder/checker for n-bit Gray, Johnson and one-hot
//            ring counter codes. Maps each code word to its sequence index,
//            flags illegal words and broken successions, tracks lock and keeps
//            a saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
module nbit_seq_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_code,
  input  logic [1:0]       mode,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [N-1:0]     idx,
  output logic             locked,
  output logic             code_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int               c_MW      = $clog2(LOCK_CNT + 1);
  localparam logic [c_MW-1:0]  c_LOCK    = c_MW'(LOCK_CNT);
  localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};
  localparam logic [N:0]       c_TWO_N   = (N+1)'(2 * N);
  localparam logic [N:0]       c_N       = (N+1)'(N);
  localparam logic [N:0]       c_POW2    = {1'b1, {N{1'b0}}};

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_ref_valid;
  logic [N-1:0]    r_expected;
  logic [c_MW-1:0] r_match_cnt;
  logic [1:0]      r_mode;

  logic [N:0]      w_lead, w_trail, w_ones, w_pos;
  logic            w_run;
  logic [N-1:0]    w_gray_idx, w_john_idx, w_ring_idx, w_idx, w_succ;
  logic            w_john_legal, w_ring_legal, w_legal;
  logic [N:0]      w_period, w_inc, w_john_hi;
  logic            w_mode_chg, w_hit, w_code_evt, w_seq_evt;
  logic [c_MW-1:0] w_match_inc;

  // Bit statistics of the incoming word: leading/trailing ones, popcount, hot position
  always_comb begin
    w_lead  = '0;
    w_trail = '0;
    w_ones  = '0;
    w_pos   = '0;
    w_run   = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_run && in_code[i]) w_lead = w_lead + 1'b1;
      else                     w_run  = 1'b0;
    end
    w_run = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (w_run && in_code[i]) w_trail = w_trail + 1'b1;
      else                     w_run   = 1'b0;
      if (in_code[i]) begin
        w_ones = w_ones + 1'b1;
        w_pos  = (N+1)'(i);
      end
    end
  end

  // Per-code decode and legality, then selection by mode
  always_comb begin
    for (int i = 0; i < N; i++) begin
      // Binary bit i of a Gray word is the XOR of all Gray bits from i upward
      w_gray_idx[i] = ^(in_code >> i);
    end

    // Legal Johnson words: zero, MSB-anchored ones run, or LSB-anchored ones run
    w_john_legal = (in_code == '0) ||
                   ( in_code[N-1] && (w_ones == w_lead)) ||
                   (!in_code[N-1] && (w_ones == w_trail));
    w_john_hi    = c_TWO_N - w_trail;
    if (in_code == '0)     w_john_idx = '0;
    else if (in_code[N-1]) w_john_idx = w_lead[N-1:0];
    else                   w_john_idx = w_john_hi[N-1:0];

    w_ring_legal = (w_ones == (N+1)'(1));
    w_ring_idx   = (w_pos == '0) ? '0 : N'(c_N - w_pos);

    case (mode)
      2'b00: begin
        w_idx    = w_gray_idx;
        w_legal  = 1'b1;
        w_period = c_POW2;
      end
      2'b01: begin
        w_idx    = w_john_idx;
        w_legal  = w_john_legal;
        w_period = c_TWO_N;
      end
      2'b10: begin
        w_idx    = w_ring_idx;
        w_legal  = w_ring_legal;
        w_period = c_N;
      end
      default: begin
        w_idx    = '0;
        w_legal  = 1'b0;
        w_period = c_N;
      end
    endcase

    // Successor is formed one bit wider so the wrap compare sees P exactly
    w_inc  = {1'b0, w_idx} + 1'b1;
    w_succ = (w_inc == w_period) ? '0 : w_inc[N-1:0];
  end

  // Succession qualifiers and error events for the current word
  always_comb begin
    w_mode_chg  = (mode != r_mode);
    w_hit       = r_ref_valid && !w_mode_chg && (w_idx == r_expected);
    w_match_inc = r_match_cnt + 1'b1;
    w_code_evt  = in_valid && !w_legal;
    w_seq_evt   = in_valid && w_legal && (r_state == ST_LOCKED) &&
                  !w_mode_chg && (w_idx != r_expected);
  end

  // Lock FSM, reference tracking, registered outputs and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_ref_valid <= 1'b0;
      r_expected  <= '0;
      r_match_cnt <= '0;
      r_mode      <= 2'b00;
      out_valid   <= 1'b0;
      idx         <= '0;
      locked      <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      out_valid <= in_valid;
      code_err  <= 1'b0;
      seq_err   <= 1'b0;

      if (err_clr)
        err_cnt <= '0;
      else if ((w_code_evt || w_seq_evt) && (err_cnt != c_ERR_MAX))
        err_cnt <= err_cnt + 1'b1;

      if (in_valid) begin
        r_mode <= mode;
        if (!w_legal) begin
          code_err    <= 1'b1;
          idx         <= '0;
          r_state     <= ST_HUNT;
          locked      <= 1'b0;
          r_ref_valid <= 1'b0;
          r_match_cnt <= '0;
        end else begin
          idx         <= w_idx;
          r_expected  <= w_succ;
          r_ref_valid <= 1'b1;
          if ((r_state == ST_LOCKED) && !w_mode_chg) begin
            if (w_idx == r_expected) begin
              locked <= 1'b1;
            end else begin
              seq_err     <= 1'b1;
              r_state     <= ST_HUNT;
              locked      <= 1'b0;
              r_match_cnt <= '0;
            end
          end else if (w_hit) begin
            if (w_match_inc == c_LOCK) begin
              r_state     <= ST_LOCKED;
              locked      <= 1'b1;
              r_match_cnt <= '0;
            end else begin
              r_state     <= ST_HUNT;
              locked      <= 1'b0;
              r_match_cnt <= w_match_inc;
            end
          end else begin
            r_state     <= ST_HUNT;
            locked      <= 1'b0;
            r_match_cnt <= '0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nbit_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbit_seq_decoder
// Brief    : Self-checking bench for nbit_seq_decoder: directed scenarios and
//            a randomized stream checked against a table-driven model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbit_seq_decoder;

  localparam int N        = 4;
  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 2;
  localparam int EMAX     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [N-1:0]     in_code = '0;
  logic [1:0]       mode = 2'b00;
  logic             err_clr = 1'b0;
  logic             out_valid;
  logic [N-1:0]     idx;
  logic             locked;
  logic             code_err;
  logic             seq_err;
  logic [ERR_W-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_locked, m_refv, m_exp, m_match, m_mode;
  int e_ov, e_idx, e_lk, e_ce, e_se, e_ec;

  nbit_seq_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_code  (in_code),
    .mode     (mode),
    .err_clr  (err_clr),
    .out_valid(out_valid),
    .idx      (idx),
    .locked   (locked),
    .code_err (code_err),
    .seq_err  (seq_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // The k-th word of each code's sequence, generated from its definition
  function automatic int codeword(input int m, input int i);
    case (m)
      0:       return i ^ (i >> 1);
      1:       return (i <= N) ? (((1 << i) - 1) << (N - i)) : ((1 << (2 * N - i)) - 1);
      2:       return (i == 0) ? 1 : (1 << (N - i));
      default: return 0;
    endcase
  endfunction

  function automatic int period(input int m);
    case (m)
      0:       return 1 << N;
      1:       return 2 * N;
      2:       return N;
      default: return 1;
    endcase
  endfunction

  // Index of a word by searching the sequence table; -1 when illegal
  function automatic int lookup(input int m, input int c);
    if (m == 3) return -1;
    for (int i = 0; i < period(m); i++)
      if (codeword(m, i) == c) return i;
    return -1;
  endfunction

  task automatic model_update(input int v, input int c, input int m, input int clr, input int r);
    int k, err, mc;
    if (r != 0) begin
      m_locked = 0; m_refv = 0; m_exp = 0; m_match = 0; m_mode = 0;
      e_ov = 0; e_idx = 0; e_lk = 0; e_ce = 0; e_se = 0; e_ec = 0;
      return;
    end
    e_ov = v; e_ce = 0; e_se = 0; err = 0;
    if (v != 0) begin
      mc = (m != m_mode);
      m_mode = m;
      k = lookup(m, c);
      if (k < 0) begin
        e_ce = 1; err = 1; e_idx = 0;
        m_locked = 0; m_refv = 0; m_match = 0;
      end else begin
        e_idx = k;
        if (m_locked != 0 && mc == 0) begin
          if (k != m_exp) begin
            e_se = 1; err = 1; m_locked = 0; m_match = 0;
          end
        end else if (m_refv != 0 && mc == 0 && k == m_exp) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_locked = 1; m_match = 0;
          end
        end else begin
          m_match = 0; m_locked = 0;
        end
        m_exp  = (k + 1) % period(m);
        m_refv = 1;
      end
      e_lk = m_locked;
    end
    if (clr != 0) e_ec = 0;
    else if (err != 0 && e_ec < EMAX) e_ec++;
  endtask

  task automatic step(input logic v, input int c, input logic [1:0] m, input logic clr, input logic r);
    @(negedge clk);
    in_valid = v; in_code = N'(c); mode = m; err_clr = clr; rst = r;
    @(posedge clk);
    model_update(int'(v), c & ((1 << N) - 1), int'(m), int'(clr), int'(r));
    #1;
    chk("out_valid", int'(out_valid), e_ov);
    chk("idx",       int'(idx),       e_idx);
    chk("locked",    int'(locked),    e_lk);
    chk("code_err",  int'(code_err),  e_ce);
    chk("seq_err",   int'(seq_err),   e_se);
    chk("err_cnt",   int'(err_cnt),   e_ec);
  endtask

  initial begin
    int cur_m, cur_i, r, c;

    // Reset state
    step(0, 0, 2'b00, 0, 1);
    step(0, 0, 2'b00, 0, 1);
    chk("rst_idx", int'(idx), 0);
    chk("rst_locked", int'(locked), 0);

    // Gray lock: idx 0..4, lock on third word
    step(1, 4'b0000, 2'b00, 0, 0);
    step(1, 4'b0001, 2'b00, 0, 0);
    chk("gray_lock_early", int'(locked), 0);
    step(1, 4'b0011, 2'b00, 0, 0);
    chk("gray_lock_third", int'(locked), 1);
    step(1, 4'b0010, 2'b00, 0, 0);
    step(1, 4'b0110, 2'b00, 0, 0);
    chk("gray_idx4", int'(idx), 4);
    // Gray sequence error then relock
    step(1, 4'b0101, 2'b00, 0, 0);
    chk("gray_seq_err", int'(seq_err), 1);
    chk("gray_seq_errcnt", int'(err_cnt), 1);
    chk("gray_seq_idx", int'(idx), 6);
    step(1, 4'b0100, 2'b00, 0, 0);
    step(1, 4'b1100, 2'b00, 0, 0);
    chk("gray_relock", int'(locked), 1);
    // Idle cycle holds idx and lock
    step(0, 4'b1111, 2'b00, 0, 0);
    chk("idle_hold_idx", int'(idx), 8);

    // Reset mid-stream, resume at idx 5
    step(0, 0, 2'b00, 0, 1);
    step(1, 4'b0111, 2'b00, 0, 0);
    chk("resume_idx5", int'(idx), 5);
    step(1, 4'b0101, 2'b00, 0, 0);
    step(1, 4'b0100, 2'b00, 0, 0);
    chk("resume_lock", int'(locked), 1);

    // Johnson wrap 6,7,0,1
    step(1, 4'b0011, 2'b01, 0, 0);
    chk("john_idx6", int'(idx), 6);
    step(1, 4'b0001, 2'b01, 0, 0);
    step(1, 4'b0000, 2'b01, 0, 0);
    chk("john_wrap_lock", int'(locked), 1);
    step(1, 4'b1000, 2'b01, 0, 0);
    chk("john_idx1", int'(idx), 1);

    // Ring lock, then illegal word, then reference-only word
    step(0, 0, 2'b10, 1, 0);
    step(1, 4'b0001, 2'b10, 0, 0);
    step(1, 4'b1000, 2'b10, 0, 0);
    step(1, 4'b0100, 2'b10, 0, 0);
    step(1, 4'b0110, 2'b10, 0, 0);
    chk("ring_code_err", int'(code_err), 1);
    chk("ring_errcnt", int'(err_cnt), 1);
    step(1, 4'b0010, 2'b10, 0, 0);
    chk("ring_no_seq_err", int'(seq_err), 0);

    // Saturation and clear priority
    step(0, 0, 2'b11, 1, 0);
    for (int i = 0; i < 5; i++) step(1, i, 2'b11, 0, 0);
    chk("sat_errcnt", int'(err_cnt), 3);
    step(1, 4'b0001, 2'b11, 1, 0);
    chk("clr_prio_cnt", int'(err_cnt), 0);
    chk("clr_prio_pulse", int'(code_err), 1);

    // Randomized stream
    cur_m = 0; cur_i = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(0, 0, 2'(cur_m), 0, 1);
      end else if (r < 10) begin
        step(0, $urandom_range(0, 15), 2'(cur_m), $urandom_range(0, 3) == 0, 0);
      end else begin
        if (r < 14) begin
          cur_m = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
          cur_i = $urandom_range(0, period(cur_m) - 1);
        end else if (r < 20) begin
          cur_i = $urandom_range(0, period(cur_m) - 1);
        end else begin
          cur_i = (cur_i + 1) % period(cur_m);
        end
        if (cur_m == 3 || r < 24) c = $urandom_range(0, 15);
        else                      c = codeword(cur_m, cur_i);
        step(1, c, 2'(cur_m), $urandom_range(0, 15) == 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
